router_input_fifo: RTL

Per-input-port flit buffer of the 5-port router (N/E/W/S/L). It sits directly upstream of the output-port arbiters. It accepts flits from the neighbouring router or the local core over the RTS/CTS one-flit handshake and holds them in a small FIFO. It presents the head flit to routing and the crossbar, and pops the head when any output arbiter grants this input.

---
 rtl/router_pkg.sv | 35 +++
 rtl/fifo_mem.sv | 33 +++
 rtl/router_input_fifo.sv | 115 +++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions.
// Holds the default flit width, the port index encoding, the one-hot output
// arbiter state constants and the one-hot crossbar select constants used
// across the 5-port router (N/E/W/S/L).
package router_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned NumPorts         = 5;

  // Port index, also the bit position of each grant in a packed grant vector.
  typedef enum logic [2:0] {
    PortN = 3'd0,
    PortE = 3'd1,
    PortW = 3'd2,
    PortS = 3'd3,
    PortL = 3'd4
  } port_idx_e;

  // One-hot output arbiter states.
  localparam logic [5:0] ArbIdle = 6'b000001;
  localparam logic [5:0] ArbL    = 6'b000010;
  localparam logic [5:0] ArbN    = 6'b000100;
  localparam logic [5:0] ArbE    = 6'b001000;
  localparam logic [5:0] ArbW    = 6'b010000;
  localparam logic [5:0] ArbS    = 6'b100000;

  // One-hot crossbar input selects, bit position follows port_idx_e.
  localparam logic [4:0] XbarSelNone = 5'b00000;
  localparam logic [4:0] XbarSelN    = 5'b00001;
  localparam logic [4:0] XbarSelE    = 5'b00010;
  localparam logic [4:0] XbarSelW    = 5'b00100;
  localparam logic [4:0] XbarSelS    = 5'b01000;
  localparam logic [4:0] XbarSelL    = 5'b10000;

endpackage

// File: rtl/fifo_mem.sv
// Flit storage for the router input FIFO.
// DEPTH x DATA_WIDTH register file, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_input_fifo.sv
// Per-input-port flit buffer of the 5-port router.
// Accepts flits over a one-flit RTS/CTS handshake, stores them in a circular
// buffer and presents the head flit first-word-fall-through. The head is
// popped whenever any of the five output arbiters grants this input.
//   clk             : clock, all state on rising edge
//   rst             : asynchronous active-low reset
//   RX              : incoming flit
//   DRTS            : upstream request-to-send
//   CTS             : clear-to-send pulse back to upstream
//   read_en_N..L    : grants from the five output arbiters
//   Data_out        : head flit (don't-care while empty)
//   empty/full      : occupancy flags, decoded from registered count
//   occupancy       : flits currently stored
//   err_multi_grant : one-cycle pulse, more than one grant in previous cycle
module router_input_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        occupancy,
  output logic                  err_multi_grant
);

  localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);
  localparam logic [PTR_W:0]   CntOne   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CntDepth = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             cts_q, cts_d;
  logic             err_q, err_d;

  logic [NumPorts-1:0] grant;
  logic                write, read;

  assign grant = {read_en_L, read_en_S, read_en_W, read_en_E, read_en_N};

  // Flags come only from registered count so no input reaches them.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntDepth);
  assign occupancy = count_q;
  assign CTS       = cts_q;
  assign err_multi_grant = err_q;

  // CTS high blocks a write, which spaces accepted flits at least 2 cycles
  // apart and keeps CTS a single-cycle pulse.
  assign write = DRTS & ~cts_q & ~full;
  assign read  = (|grant) & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cts_d    = write;
    err_d    = ($countones(grant) > 1);

    if (write) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (read) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({write, read})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cts_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cts_q    <= cts_d;
      err_q    <= err_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (write),
    .waddr(wr_ptr_q),
    .wdata(RX),
    .raddr(rd_ptr_q),
    .rdata(Data_out)
  );

endmodule
